// File: rtl/cache_types_pkg.sv
// Types and default geometry shared by the cache-side / memory-side bridge logic.
package cache_types;

    localparam int s_offset  = 5;
    localparam int s_line    = 8 * (2 ** s_offset);
    localparam int s_beat    = 64;
    localparam int num_beats = s_line / s_beat;
    localparam int cnt_w     = (num_beats > 1) ? $clog2(num_beats) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/line_burst_adaptor.sv
// Converts between full cache lines and ascending 64-bit memory bursts,
// one line transaction at a time.
//
// state | meaning
// IDLE  | waiting for a fill (read_i) or writeback (write_i) request
// READ  | fill burst: each accepted beat lands in line_o at the beat index
// WRITE | writeback burst: buffered line driven out one beat per accept
// DONE  | one-cycle resp_o pulse, then back to IDLE
module line_burst_adaptor
    import cache_types::*;
#(
    parameter int s_offset = cache_types::s_offset,
    parameter int s_beat   = cache_types::s_beat
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [31:0]                 address_i,
    input  logic                        read_i,
    input  logic                        write_i,
    input  logic [8*(2**s_offset)-1:0]  line_i,
    output logic [8*(2**s_offset)-1:0]  line_o,
    output logic                        resp_o,
    output logic [31:0]                 address_o,
    output logic                        read_o,
    output logic                        write_o,
    output logic [s_beat-1:0]           burst_o,
    input  logic [s_beat-1:0]           burst_i,
    input  logic                        resp_i
);

    localparam int s_line    = 8 * (2 ** s_offset);
    localparam int num_beats = s_line / s_beat;
    localparam int cnt_w     = (num_beats > 1) ? $clog2(num_beats) : 1;

    localparam logic [cnt_w-1:0] last_beat = cnt_w'(num_beats - 1);
    localparam logic [cnt_w-1:0] one_beat  = cnt_w'(1);
    localparam logic [31:0]      off_mask  = 32'((64'd1 << s_offset) - 64'd1);

    state_t               state;
    state_t               state_n;
    logic [cnt_w-1:0]     cnt;
    logic [31:0]          addr_q;
    logic [s_line-1:0]    line_q;
    logic [s_line-1:0]    buf_q;
    logic                 beat_done;

    assign beat_done = resp_i && (cnt == last_beat);

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE: begin
                if (write_i)     state_n = WRITE;
                else if (read_i) state_n = READ;
            end
            READ:    if (beat_done) state_n = DONE;
            WRITE:   if (beat_done) state_n = DONE;
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Counter stops at the last beat so it never wraps inside a transaction.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt    <= '0;
            addr_q <= '0;
            line_q <= '0;
            buf_q  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (write_i) begin
                        buf_q  <= line_i;
                        addr_q <= address_i & ~off_mask;
                        cnt    <= '0;
                    end else if (read_i) begin
                        addr_q <= address_i & ~off_mask;
                        cnt    <= '0;
                    end
                end
                READ: begin
                    if (resp_i) begin
                        line_q[int'(cnt)*s_beat +: s_beat] <= burst_i;
                        if (cnt != last_beat) cnt <= cnt + one_beat;
                    end
                end
                WRITE: begin
                    if (resp_i && (cnt != last_beat)) cnt <= cnt + one_beat;
                end
                default: ;
            endcase
        end
    end

    assign read_o    = (state == READ);
    assign write_o   = (state == WRITE);
    assign resp_o    = (state == DONE);
    assign address_o = addr_q;
    assign line_o    = line_q;
    assign burst_o   = buf_q[int'(cnt)*s_beat +: s_beat];

endmodule

// File: doc/line_burst_adaptor.md
# line_burst_adaptor

Bridges the cache's full-line datapath and the 64-bit burst interface of physical memory. On a fill it assembles consecutive memory beats into one cache line for the data array's write port. On a writeback it captures a full line read from the data array and serialises it into beats. It sits directly between the cache datapath/controller and the memory port, handling one line transaction at a time under a small FSM.

## Interface
- s_offset, default 5: log2 bytes per line; line width s_line = 8·2^s_offset (256).
- s_beat, default 64: memory beat width in bits; num_beats = s_line/s_beat (4); s_line must be a multiple of s_beat.
- clk  in  1  clock; all state changes on posedge clk.
- rst  in  1  reset, synchronous, active-high.
- address_i  in  32  line address from cache controller.
- read_i  in  1  fill request.
- write_i  in  1  writeback request.
- line_i  in  s_line  line to write back, from data array dataout.
- line_o  out  s_line  assembled fill line, to data array datain.
- resp_o  out  1  one-cycle transaction-complete pulse.
- address_o  out  32  line-aligned memory address.
- read_o  out  1  memory read burst request.
- write_o  out  1  memory write burst request.
- burst_o  out  s_beat  current write beat.
- burst_i  in  s_beat  incoming read beat.
- resp_i  in  1  memory beat accept/valid strobe.

## Operation
- States: IDLE, READ, WRITE, DONE.
- IDLE:
  - write_i=1 → WRITE. Latch line_i into the write buffer, latch address, beat counter=0.
  - Else read_i=1 → READ. Latch address, beat counter=0.
  - write_i has priority when both are high.
- Address: address_o = {address_i[31:s_offset], s_offset'b0}, latched on accept and held constant through DONE.
- READ:
  - read_o=1.
  - Each cycle with resp_i=1, line_o[s_beat·k +: s_beat] ← burst_i, where k is the beat counter; then k++.
  - On the beat with k = num_beats−1 → DONE.
- WRITE:
  - write_o=1; burst_o = buffer[s_beat·k +: s_beat].
  - Each cycle with resp_i=1, k++.
  - On the final beat → DONE.
- Beat order is ascending (beat 0 = bits [s_beat−1:0]).
- DONE: resp_o=1, read_o=write_o=0. Unconditionally → IDLE.
- The requester deasserts read_i/write_i in the cycle after resp_o. A request still high in that IDLE cycle is accepted as a new transaction.
- resp_i in IDLE or DONE is ignored.
- line_o holds its last assembled value until the next fill overwrites it beat by beat. It is complete and valid only while resp_o=1 after a READ and afterwards.
- Beat counter width is $clog2(num_beats). It never wraps inside a transaction; it is cleared on accept.

## Timing
- Reset values:
  - state=IDLE.
  - read_o, write_o, resp_o = 0.
  - address_o, line_o, burst_o, write buffer = 0.
  - counter = 0.
- All outputs are registered or decoded from registered state only. No combinational path from inputs to outputs.
- Accept cycle T (IDLE, request high) → read_o/write_o high from T+1.
- With resp_i high every cycle, the final beat lands at T+num_beats, resp_o is high at T+num_beats+1, and the FSM is IDLE at T+num_beats+2.
- Memory may stall: resp_i low holds the counter, burst_o and address_o unchanged.
- rst mid-transaction:
  - Next cycle is IDLE with all outputs at reset values.
  - No resp_o is produced.
  - A partially assembled line is discarded (line_o cleared).

## Structure
- Shared package cache_types: s_beat, num_beats, the counter width, and the state enum (IDLE/READ/WRITE/DONE).
- Single module, no sub-module. The beat counter and FSM are inline.

## Test plan
- Fill, no stalls: address_i=0x1234_5678, read_i; burst_i=0x11…11, 0x22…22, 0x33…33, 0x44…44 on 4 consecutive cycles.
  - address_o=0x1234_5660.
  - resp_o at T+5.
  - line_o = {0x44…44, 0x33…33, 0x22…22, 0x11…11}.
- Writeback with stalls: line_i = 256'h0123…cdef, write_i; resp_i pattern 1,0,0,1,1,0,1.
  - burst_o steps through bits [63:0]..[255:192] only on resp_i.
  - burst_o is held during stalls.
  - resp_o occurs exactly once, after the 4th beat.
- Simultaneous read_i and write_i in IDLE: WRITE is taken and write_o=1. read_o stays 0 for the whole transaction.
- Back-to-back: write_i kept high in the cycle after resp_o. A second writeback starts with counter=0 and a freshly latched line_i.
- Reset after 2 of 4 read beats:
  - Next cycle read_o=0, resp_o=0, line_o=0, state IDLE.
  - A subsequent fill completes normally.
- resp_i pulses while IDLE: no state change, no resp_o, line_o unchanged.
